// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   REG_LEN     : architectural register width
//   MULDIV_ITER : number of radix-2 iterations per iterative op
//   muldiv_op_t : funct3 encodings of the RV32M ops
//   muldiv_state_t : control FSM states
// Helper functions decode operand signedness and op class from muldiv_op_t.
package rysyPkg;

  localparam int unsigned REG_LEN     = 32;
  localparam int unsigned MULDIV_ITER = REG_LEN;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } muldiv_state_t;

  function automatic logic op_is_mul(muldiv_op_t op);
    return ~op[2];
  endfunction

  function automatic logic op_is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(muldiv_op_t op);
    return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
           (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_b_signed(muldiv_op_t op);
    return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step, purely combinational.
//   i_part_rem : shifted partial remainder {rem, next dividend bit}
//   i_divisor  : divisor magnitude
//   o_rem_nxt  : remainder after the conditional subtract
//   o_q_bit    : quotient bit produced by this step
module div_step
  import rysyPkg::*;
(
  input  logic [REG_LEN:0]   i_part_rem,
  input  logic [REG_LEN-1:0] i_divisor,
  output logic [REG_LEN-1:0] o_rem_nxt,
  output logic               o_q_bit
);

  logic w_ge;

  assign w_ge      = i_part_rem >= {1'b0, i_divisor};
  assign o_q_bit   = w_ge;
  // When the subtract happens the difference is below the divisor, so 32 bits hold it.
  assign o_rem_nxt = w_ge ? (i_part_rem[REG_LEN-1:0] - i_divisor) : i_part_rem[REG_LEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with a register-file writeback interface.
// Iterative path: 32 radix-2 steps on operand magnitudes (shift-add multiply,
// restoring divide), sign applied at the end.
//   clk, rst (async, active-high)
//   start, funct3, rs1_d, rs2_d, rd_in : op request, sampled only in IDLE
//   kill                               : aborts an op in CALC
//   busy, done, result, rd_out, reg_wr : status and writeback
// Optional macro MULDIV_FAST_MUL_EN: MUL* ops complete in one cycle through a
// hardware multiplier; divides stay iterative.
module muldiv_unit
  import rysyPkg::*;
#(
  parameter int unsigned ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          funct3,
  input  logic [REG_LEN-1:0]  rs1_d,
  input  logic [REG_LEN-1:0]  rs2_d,
  input  logic [ADDR_LEN-1:0] rd_in,
  input  logic                kill,
  output logic                busy,
  output logic                done,
  output logic [REG_LEN-1:0]  result,
  output logic [ADDR_LEN-1:0] rd_out,
  output logic                reg_wr
);

  localparam int unsigned         CNT_W    = $clog2(MULDIV_ITER);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MULDIV_ITER - 1);

  muldiv_state_t          r_state, w_state_nxt;
  muldiv_op_t             r_op, w_op;
  logic                   r_neg, r_divz;
  logic [REG_LEN-1:0]     r_opa, r_opb, r_result;
  logic [2*REG_LEN-1:0]   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_LEN-1:0]    r_rd;

  logic                   w_accept, w_a_neg, w_b_neg;
  logic [REG_LEN-1:0]     w_a_mag, w_b_mag;
  logic [REG_LEN:0]       w_mul_sum;
  logic [REG_LEN-1:0]     w_div_rem;
  logic                   w_div_q;
  logic [2*REG_LEN-1:0]   w_acc_nxt, w_prod;
  logic [REG_LEN-1:0]     w_quo, w_rem, w_final;
  logic                   w_fast;
  logic [REG_LEN-1:0]     w_fast_res;

  // Request decode
  assign w_op     = muldiv_op_t'(funct3);
  assign w_accept = (r_state == StIdle) && start && !kill;
  assign w_a_neg  = op_a_signed(w_op) & rs1_d[REG_LEN-1];
  assign w_b_neg  = op_b_signed(w_op) & rs2_d[REG_LEN-1];
  assign w_a_mag  = w_a_neg ? -rs1_d : rs1_d;
  assign w_b_mag  = w_b_neg ? -rs2_d : rs2_d;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*REG_LEN-1:0] w_fa, w_fb, w_fprod;
  // Sign/zero extension to 64 bits gives the same low 64 bits as a 33x33 signed product.
  assign w_fa       = {{REG_LEN{w_a_neg}}, rs1_d};
  assign w_fb       = {{REG_LEN{w_b_neg}}, rs2_d};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast     = op_is_mul(w_op);
  assign w_fast_res = (w_op == OpMul) ? w_fprod[REG_LEN-1:0] : w_fprod[2*REG_LEN-1:REG_LEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  // Multiply: r_acc = {partial high, remaining multiplier}, r_opb = multiplicand.
  assign w_mul_sum = {1'b0, r_acc[2*REG_LEN-1:REG_LEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);

  // Divide: r_acc = {remainder, dividend shifting into quotient}, r_opb = divisor.
  div_step u_div_step (
    .i_part_rem ({r_acc[2*REG_LEN-1:REG_LEN], r_acc[REG_LEN-1]}),
    .i_divisor  (r_opb),
    .o_rem_nxt  (w_div_rem),
    .o_q_bit    (w_div_q)
  );

  assign w_acc_nxt = op_is_mul(r_op) ? {w_mul_sum, r_acc[REG_LEN-1:1]}
                                     : {w_div_rem, r_acc[REG_LEN-2:0], w_div_q};

  // Result of the final iteration, signs restored
  always_comb begin
    w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_quo   = r_neg ? -w_acc_nxt[REG_LEN-1:0] : w_acc_nxt[REG_LEN-1:0];
    w_rem   = r_neg ? -w_acc_nxt[2*REG_LEN-1:REG_LEN] : w_acc_nxt[2*REG_LEN-1:REG_LEN];
    w_final = '0;
    unique case (r_op)
      OpMul:                     w_final = w_prod[REG_LEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: w_final = w_prod[2*REG_LEN-1:REG_LEN];
      OpDiv, OpDivu:             w_final = r_divz ? '1 : w_quo;
      default:                   w_final = r_divz ? r_opa : w_rem;
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_nxt = w_fast ? StDone : StCalc;
      StCalc: begin
        if (kill)                    w_state_nxt = StIdle;
        else if (r_cnt == CNT_LAST)  w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OpMul;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= w_op;
      r_rd   <= rd_in;
      r_opa  <= rs1_d;
      r_cnt  <= '0;
      r_divz <= !op_is_mul(w_op) && (rs2_d == '0);
      // Remainder takes the dividend's sign; product and quotient take the XOR.
      r_neg  <= op_is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
      if (op_is_mul(w_op)) begin
        r_opb <= w_a_mag;
        r_acc <= {{REG_LEN{1'b0}}, w_b_mag};
      end else begin
        r_opb <= w_b_mag;
        r_acc <= {{REG_LEN{1'b0}}, w_a_mag};
      end
      if (w_fast) r_result <= w_fast_res;
    end else if (r_state == StCalc && !kill) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) r_result <= w_final;
    end
  end

  assign busy   = (r_state != StIdle);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign rd_out = r_rd;
  assign reg_wr = done && (r_rd != '0);

endmodule
